// File: rtl/biu_mem_responder.sv
// biu_mem_responder: BIU target that runs MOV/LOAD/STORE against the register file and memory port.
// Optional memory-ack watchdog enabled by defining BIU_TIMEOUT_EN.
module biu_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int RF_AW   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_biu,
    input  logic [1:0]        sel_biu,
    input  logic [31:0]       ir,
    output logic              ready_bus,
    output logic              err,
    output logic [RF_AW-1:0]  rf_raddr_a,
    input  logic [DATA_W-1:0] rf_rdata_a,
    output logic [RF_AW-1:0]  rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [2:0] {IDLE, OPRD, MEM, WB, DONE} state_t;

    state_t             state, state_n;
    logic [31:0]        ir_q;
    logic               ls_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  res_q;
    logic               done_q;
    logic               err_q;
    logic               req;
    logic               tmo;
    logic               unused_bits;

    // A floating or low cs_biu is idle; only a driven 1 is a request.
    assign req = (cs_biu === 1'b1);

    assign rf_raddr_a  = RF_AW'(state == IDLE ? ir[9:5]   : ir_q[9:5]);
    assign rf_raddr_b  = RF_AW'(state == IDLE ? ir[14:10] : ir_q[14:10]);
    assign rf_waddr    = RF_AW'(ir_q[14:10]);
    assign rf_wdata    = res_q;
    assign rf_we       = (state == WB);
    assign mem_req     = (state == MEM);
    assign mem_we      = (state == MEM) && ir_q[18];
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign ready_bus   = (state == DONE);
    assign err         = err_q;
    assign unused_bits = ^{ir[31:20], ir[17:15], ir[4:0], ir_q[31:20], ir_q[17:15]};

`ifdef BIU_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt <= '0;
        else     tmo_cnt <= (state == MEM) ? tmo_cnt + 1'b1 : '0;
    end
    assign tmo = (state == MEM) && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req ? (sel_biu[1] ? DONE : OPRD) : IDLE;
            OPRD:    state_n = ls_q ? MEM : WB;
            MEM:     state_n = mem_ack ? (ir_q[18] ? DONE : WB) : (tmo ? DONE : MEM);
            WB:      state_n = DONE;
            DONE:    state_n = (done_q && !req) ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q    <= '0;
            ls_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                ir_q <= ir;
                ls_q <= sel_biu[0];
            end
            if (state == OPRD) begin
                addr_q  <= ADDR_W'(rf_rdata_a + DATA_W'(ir_q[4:0]));
                wdata_q <= rf_rdata_b;
                res_q   <= ir_q[19] ? DATA_W'(ir_q[9:0]) : rf_rdata_a;
            end
            if (state == MEM && mem_ack && !ir_q[18]) res_q <= mem_rdata;
            done_q <= (state == DONE);
            // err is raised by a reserved dispatch or a watchdog expiry and cleared on return to IDLE.
            err_q  <= (state == IDLE) ? (req && sel_biu[1]) : ((state_n != IDLE) && (err_q || tmo));
        end
    end
endmodule

// File: tb/tb_biu_mem_responder.sv
// tb_biu_mem_responder: directed checks of MOV, LOAD, STORE wrap, reserved select and reset abort.
// The watchdog sequence runs only when BIU_TIMEOUT_EN is defined (TIMEOUT=8).
module tb_biu_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_biu = 1'b0;
    logic [1:0]  sel_biu = 2'b00;
    logic [31:0] ir = '0;
    logic        ready_bus, err, rf_we, mem_req, mem_we;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_addr;
    logic [31:0] rf [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    biu_mem_responder #(.DATA_W(32), .ADDR_W(16), .RF_AW(5), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cs_biu(cs_biu), .sel_biu(sel_biu), .ir(ir),
        .ready_bus(ready_bus), .err(err),
        .rf_raddr_a(rf_raddr_a), .rf_rdata_a(rf_rdata_a),
        .rf_raddr_b(rf_raddr_b), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[2] = 32'h0000_00F0;
        rf[4] = 32'h0000_FFFE;
        rf[5] = 32'h1234_5678;
        cyc();
        chk("rst_ready", ready_bus, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        cyc();

        // MOV immediate
        ir = '0; ir[21:19] = 3'b101; ir[14:10] = 5'd3; ir[9:0] = 10'h2A5;
        cs_biu = 1'b1; sel_biu = 2'b00;
        cyc();
        chk("mov_oprd_ready", ready_bus, 0);
        chk("mov_oprd_we", rf_we, 0);
        cyc();
        chk("mov_wb_we", rf_we, 1);
        chk("mov_wb_addr", rf_waddr, 3);
        chk("mov_wb_data", rf_wdata, 32'h2A5);
        chk("mov_wb_ready", ready_bus, 0);
        cyc();
        chk("mov_done_ready", ready_bus, 1);
        chk("mov_done_we", rf_we, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mov_hold_ready", ready_bus, 1);
        end
        cs_biu = 1'b0;
        cyc();
        chk("mov_idle_ready", ready_bus, 0);

        // LOAD, memory acks after 3 wait cycles
        ir = '0; ir[18] = 1'b0; ir[14:10] = 5'd7; ir[9:5] = 5'd2; ir[4:0] = 5'h0F;
        cs_biu = 1'b1; sel_biu = 2'b01;
        cyc();
        chk("ld_oprd_req", mem_req, 0);
        cyc();
        chk("ld_mem_req", mem_req, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_mem_addr", mem_addr, 32'h00FF);
        cyc();
        chk("ld_wait2_req", mem_req, 1);
        cyc();
        chk("ld_wait3_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("ld_wb_we", rf_we, 1);
        chk("ld_wb_addr", rf_waddr, 7);
        chk("ld_wb_data", rf_wdata, 32'hDEAD_BEEF);
        chk("ld_wb_req", mem_req, 0);
        chk("ld_wb_ready", ready_bus, 0);
        cyc();
        chk("ld_done_ready", ready_bus, 1);
        cs_biu = 1'b0;
        cyc();
        chk("ld_done_min2", ready_bus, 1);
        cyc();
        chk("ld_idle_ready", ready_bus, 0);

        // STORE with address wrap; cs_biu drops mid-operation
        ir = '0; ir[18] = 1'b1; ir[14:10] = 5'd5; ir[9:5] = 5'd4; ir[4:0] = 5'd4;
        cs_biu = 1'b1; sel_biu = 2'b01;
        cyc();
        chk("st_oprd_req", mem_req, 0);
        cs_biu = 1'b0;
        cyc();
        chk("st_mem_req", mem_req, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 32'h0002);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("st_done_ready", ready_bus, 1);
        chk("st_done_req", mem_req, 0);
        chk("st_done_we", rf_we, 0);
        cyc();
        chk("st_done2_ready", ready_bus, 1);
        chk("st_done2_we", rf_we, 0);
        cyc();
        chk("st_idle_ready", ready_bus, 0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_ready", ready_bus, 0);

        // Reserved select
        ir = '0; cs_biu = 1'b1; sel_biu = 2'b10;
        cyc();
        chk("rsv_ready", ready_bus, 1);
        chk("rsv_err", err, 1);
        chk("rsv_req", mem_req, 0);
        chk("rsv_we", rf_we, 0);
        cs_biu = 1'b0;
        cyc();
        chk("rsv_done2_err", err, 1);
        chk("rsv_done2_we", rf_we, 0);
        cyc();
        chk("rsv_idle_ready", ready_bus, 0);
        chk("rsv_idle_err", err, 0);

        // Asynchronous reset during MEM
        ir = '0; ir[14:10] = 5'd7; ir[9:5] = 5'd2; ir[4:0] = 5'h0F;
        cs_biu = 1'b1; sel_biu = 2'b01;
        cyc();
        cyc();
        chk("ar_mem_req", mem_req, 1);
        cs_biu = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_req_drop", mem_req, 0);
        chk("ar_ready", ready_bus, 0);
        chk("ar_addr", mem_addr, 0);
        rst = 1'b0;
        cyc();
        ir = '0; ir[19] = 1'b0; ir[14:10] = 5'd9; ir[9:5] = 5'd5;
        cs_biu = 1'b1; sel_biu = 2'b00;
        cyc();
        chk("ar_mov_oprd_ready", ready_bus, 0);
        cyc();
        chk("ar_mov_we", rf_we, 1);
        chk("ar_mov_addr", rf_waddr, 9);
        chk("ar_mov_data", rf_wdata, 32'h1234_5678);
        cs_biu = 1'b0;
        cyc();
        chk("ar_mov_ready", ready_bus, 1);
        cyc();
        cyc();
        chk("ar_mov_idle", ready_bus, 0);

`ifdef BIU_TIMEOUT_EN
        // Watchdog: mem_ack never arrives within TIMEOUT=8 MEM cycles
        ir = '0; ir[14:10] = 5'd7; ir[9:5] = 5'd2; ir[4:0] = 5'h0F;
        cs_biu = 1'b1; sel_biu = 2'b01;
        cyc();
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("to_mem_req", mem_req, 1);
        end
        cyc();
        chk("to_req_drop", mem_req, 0);
        chk("to_err", err, 1);
        chk("to_ready", ready_bus, 1);
        cs_biu = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        cyc();
        mem_ack = 1'b0;
        chk("to_late_we", rf_we, 0);
        chk("to_late_ready", ready_bus, 1);
        cyc();
        chk("to_idle_ready", ready_bus, 0);
        chk("to_idle_err", err, 0);
        chk("to_idle_req", mem_req, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
